// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle between two requesters, the arbiter and the shared ALU.
// slave: the arbiter side; master: the requester/ALU environment side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_op;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_result;
    logic             rsp0_zero;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_result;
    logic             rsp1_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero,
        input  rsp0_ready,
        output rsp1_valid, rsp1_result, rsp1_zero,
        input  rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero,
        output rsp0_ready,
        input  rsp1_valid, rsp1_result, rsp1_zero,
        output rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU, one op in flight at a time.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; grant is presented combinationally as reqN_ready
// ISSUE | latched operands drive the ALU; result captured at the next edge
// RESP  | response held on the granted requester until its rsp_ready
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             grant_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic             tie_gnt;
    logic             gnt;
    logic             accept;
    logic             ready0;
    logic             ready1;
    logic             rsp_done;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= gnt;
        end
    end

    assign tie_gnt = ~last_grant;
`else
    assign tie_gnt = 1'b0;
`endif

    always_comb begin
        next_state = state;
        gnt        = 1'b0;
        accept     = 1'b0;
        ready0     = 1'b0;
        ready1     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    gnt = tie_gnt;
                end else begin
                    gnt = bus.req1_valid;
                end
                ready0 = bus.req0_valid && !gnt;
                ready1 = bus.req1_valid && gnt;
                accept = ready0 || ready1;
                if (accept) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_done = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            grant_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                grant_q <= gnt;
                a_q     <= gnt ? bus.req1_a  : bus.req0_a;
                b_q     <= gnt ? bus.req1_b  : bus.req0_b;
                op_q    <= gnt ? bus.req1_op : bus.req0_op;
            end
            if (state == ISSUE) begin
                result_q <= bus.alu_result;
                zero_q   <= bus.alu_zero;
            end
        end
    end

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;

    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;

    assign bus.rsp0_valid  = (state == RESP) && !grant_q;
    assign bus.rsp1_valid  = (state == RESP) && grant_q;
    assign bus.rsp0_result = result_q;
    assign bus.rsp1_result = result_q;
    assign bus.rsp0_zero   = zero_q;
    assign bus.rsp1_zero   = zero_q;

endmodule
